vigna_m_issue: RTL and testbench

VIGNA_M_ISSUE -- requirements
Module: vigna_m_issue

---
 rtl/vigna_m_issue.sv | 114 +++++++++++
 tb/tb_vigna_m_issue.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vigna_m_issue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vigna_m_issue : RV32M issue stage, hands one instruction at a time to an
//                 external M unit and returns its result as a writeback.
// Revision 1.0
// ----------------------------------------------------------------------------
module vigna_m_issue (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_rs1_val,
   input  logic [31:0] in_rs2_val,
   input  logic [2:0]  in_tag,
   output logic        cp_valid,
   input  logic        cp_ready,
   output logic [2:0]  cp_func,
   output logic [2:0]  cp_id,
   output logic [31:0] cp_op1,
   output logic [31:0] cp_op2,
   input  logic [31:0] cp_result,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [2:0]  wb_tag,
   output logic        wb_err
);

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_WB    = 2'd3
   } state_t;

   state_t     state;
   logic       is_m;
   logic [4:0] rd;
   logic       unused_fields;

   assign is_m = (in_instr[6:0] == OPC_OP) && (in_instr[31:25] == F7_MULDIV);
   assign rd   = in_instr[11:7];
   // Register-specifier fields are not needed: operand values arrive pre-read.
   assign unused_fields = ^in_instr[24:15];

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         in_ready <= 1'b1;
         cp_valid <= 1'b0;
         cp_func  <= 3'd0;
         cp_id    <= 3'd0;
         cp_op1   <= 32'd0;
         cp_op2   <= 32'd0;
         wb_valid <= 1'b0;
         wb_rd    <= 5'd0;
         wb_data  <= 32'd0;
         wb_tag   <= 3'd0;
         wb_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  wb_rd    <= rd;
                  wb_tag   <= in_tag;
                  if (is_m && (rd != 5'd0)) begin
                     state    <= S_ISSUE;
                     cp_valid <= 1'b1;
                     cp_func  <= in_instr[14:12];
                     cp_id    <= in_tag;
                     cp_op1   <= in_rs1_val;
                     cp_op2   <= in_rs2_val;
                  end else begin
                     // Writes to x0 and non-M instructions complete locally.
                     state    <= S_WB;
                     wb_valid <= 1'b1;
                     wb_data  <= 32'd0;
                     wb_err   <= ~is_m;
                  end
               end
            end
            S_ISSUE: begin
               cp_valid <= 1'b0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               // Request fields stay frozen here; the M unit re-reads them on completion.
               if (cp_ready) begin
                  wb_data  <= cp_result;
                  wb_err   <= 1'b0;
                  wb_valid <= 1'b1;
                  state    <= S_WB;
               end
            end
            S_WB: begin
               if (wb_ready) begin
                  wb_valid <= 1'b0;
                  in_ready <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vigna_m_issue.sv
`default_nettype none
// tb_vigna_m_issue : directed RV32M cases plus randomized traffic against a
//                    transaction-level model of the issue stage.
module tb_vigna_m_issue;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs1_val;
   logic [31:0] in_rs2_val;
   logic [2:0]  in_tag;
   logic        cp_valid;
   logic        cp_ready;
   logic [2:0]  cp_func;
   logic [2:0]  cp_id;
   logic [31:0] cp_op1;
   logic [31:0] cp_op2;
   logic [31:0] cp_result;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [2:0]  wb_tag;
   logic        wb_err;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   vigna_m_issue dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_rs1_val (in_rs1_val),
      .in_rs2_val (in_rs2_val),
      .in_tag     (in_tag),
      .cp_valid   (cp_valid),
      .cp_ready   (cp_ready),
      .cp_func    (cp_func),
      .cp_id      (cp_id),
      .cp_op1     (cp_op1),
      .cp_op2     (cp_op2),
      .cp_result  (cp_result),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .wb_tag     (wb_tag),
      .wb_err     (wb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // RISC-V M-extension arithmetic, including divide-by-zero and overflow rules.
   function automatic logic [31:0] m_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub_s;
      logic [63:0] ua, ub, p;
      logic [31:0] r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      ub_s = $signed(ub);
      p = 64'd0;
      r = 32'd0;
      case (f)
         3'd0: begin p = ua * ub; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub_s; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: begin
            if (b == 32'd0) r = 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
            else r = $signed(a) / $signed(b);
         end
         3'd5: r = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 32'd0) r = a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
            else r = $signed(a) % $signed(b);
         end
         default: r = (b == 32'd0) ? a : a % b;
      endcase
      return r;
   endfunction

   // ---------------- transaction-level reference model ----------------
   bit          m_have, m_need, m_done, m_fresh, m_err;
   int          m_age;
   logic [2:0]  m_func, m_tag;
   logic [4:0]  m_rd;
   logic [31:0] m_op1, m_op2, m_res;

   always @(posedge clk) begin
      if (reset) begin
         m_have  = 1'b0;
         m_fresh = 1'b1;
      end else if (!m_have) begin
         if (in_valid) begin
            m_have  = 1'b1;
            m_fresh = 1'b0;
            m_age   = 0;
            m_func  = in_instr[14:12];
            m_tag   = in_tag;
            m_rd    = in_instr[11:7];
            m_op1   = in_rs1_val;
            m_op2   = in_rs2_val;
            m_err   = !(in_instr[6:0] == 7'h33 && in_instr[31:25] == 7'h01);
            m_need  = !m_err && (m_rd != 5'd0);
            m_done  = !m_need;
            m_res   = 32'd0;
         end
      end else if (!m_done) begin
         if (m_age >= 1 && cp_ready) begin
            m_done = 1'b1;
            m_res  = m_ref(m_func, m_op1, m_op2);
         end
         m_age++;
      end else if (wb_ready) begin
         m_have = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, !m_have);
         chk("cp_valid", cp_valid, m_have && m_need && !m_done && m_age == 0);
         chk("wb_valid", wb_valid, m_have && m_done);
         if (m_have && m_need && !m_done) begin
            chk("cp_func", cp_func, m_func);
            chk("cp_id", cp_id, m_tag);
            chk("cp_op1", cp_op1, m_op1);
            chk("cp_op2", cp_op2, m_op2);
         end
         if (m_have && m_done) begin
            chk("wb_rd", wb_rd, m_rd);
            chk("wb_tag", wb_tag, m_tag);
            chk("wb_data", wb_data, m_res);
            chk("wb_err", wb_err, m_err);
         end
         if (m_fresh) begin
            chk("rst_cp", {cp_func, cp_id}, 32'd0);
            chk("rst_op1", cp_op1, 32'd0);
            chk("rst_op2", cp_op2, 32'd0);
            chk("rst_wb", {wb_err, wb_rd, wb_tag}, 32'd0);
            chk("rst_data", wb_data, 32'd0);
         end
      end
   end

   // ---------------- stimulus and M-unit responder ----------------
   int pend       = 0;
   int resp_delay = 0;
   bit resp_en    = 1'b1;
   bit stray_en   = 1'b0;
   bit stray_once = 1'b0;

   task automatic tick();
      @(negedge clk);
      cp_ready  = 1'b0;
      cp_result = $urandom;
      if (reset) pend = 0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            cp_ready  = 1'b1;
            cp_result = m_ref(cp_func, cp_op1, cp_op2);
         end
      end else if (cp_valid && resp_en) begin
         pend = (resp_delay > 0) ? resp_delay : $urandom_range(1, 4);
      end else if (stray_once || (stray_en && $urandom_range(0, 4) == 0)) begin
         cp_ready = 1'b1;
      end
      stray_once = 1'b0;
   endtask

   task automatic offer(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] tag);
      tick();
      in_valid   = 1'b1;
      in_instr   = instr;
      in_rs1_val = a;
      in_rs2_val = b;
      in_tag     = tag;
      tick();
      in_valid   = 1'b0;
   endtask

   task automatic wait_wb();
      for (int n = 0; n < 30 && !wb_valid; n++) tick();
      chk("wb_wait", wb_valid, 1'b1);
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 3))
         0, 1: begin
            w[31:25] = 7'b0000001;
            w[6:0]   = 7'b0110011;
            if ($urandom_range(0, 5) == 0) w[11:7] = 5'd0;
         end
         2: begin
            w[31:25] = 7'b0000000;
            w[6:0]   = 7'b0110011;
         end
         default: ;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] gen_op();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_instr   = 32'd0;
      in_rs1_val = 32'd0;
      in_rs2_val = 32'd0;
      in_tag     = 3'd0;
      cp_ready   = 1'b0;
      cp_result  = 32'd0;
      wb_ready   = 1'b1;
      repeat (3) tick();
      chk_en = 1'b1;
      reset  = 1'b0;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_valids", {cp_valid, wb_valid, wb_err}, 32'd0);

      // MUL x3,x1,x2
      offer(32'h022081B3, 32'd7, 32'd6, 3'd2);
      chk("mul_cp_valid", cp_valid, 1'b1);
      chk("mul_func", cp_func, 3'd0);
      chk("mul_ops", {cp_op1[15:0], cp_op2[15:0]}, 32'h00070006);
      chk("mul_id", cp_id, 3'd2);
      wait_wb();
      chk("mul_rd", wb_rd, 5'd3);
      chk("mul_data", wb_data, 32'd42);
      chk("mul_tag_err", {wb_tag, wb_err}, {3'd2, 1'b0});

      // DIVU x5,x1,x2 with zero divisor
      offer(32'h0220D2B3, 32'd100, 32'd0, 3'd1);
      chk("divu_func", cp_func, 3'd5);
      wait_wb();
      chk("divu_data", wb_data, 32'hFFFFFFFF);
      chk("divu_rd", wb_rd, 5'd5);

      // ADD x3,x1,x2 is not RV32M
      offer(32'h002081B3, 32'd1, 32'd2, 3'd3);
      chk("add_cp_valid", cp_valid, 1'b0);
      chk("add_wb", {wb_valid, wb_err}, 2'b11);
      chk("add_data", wb_data, 32'd0);

      // MUL x0,x1,x2 writes nothing useful
      offer(32'h02208033, 32'd5, 32'd5, 3'd4);
      chk("x0_cp_valid", cp_valid, 1'b0);
      chk("x0_wb", {wb_valid, wb_err, wb_rd}, {1'b1, 1'b0, 5'd0});
      chk("x0_data", wb_data, 32'd0);

      // Writeback back-pressure with operand hold during WAIT
      tick();
      wb_ready   = 1'b0;
      resp_delay = 3;
      offer(32'h022081B3, 32'hFFFFFFFF, 32'd2, 3'd6);
      for (int n = 0; n < 20 && !wb_valid; n++) begin
         tick();
         if (!wb_valid && !cp_valid) begin
            chk("hold_op1", cp_op1, 32'hFFFFFFFF);
            chk("hold_op2", cp_op2, 32'd2);
         end
      end
      chk("bp_wb_wait", wb_valid, 1'b1);
      for (int k = 0; k < 10; k++) begin
         chk("bp_data", wb_data, 32'hFFFFFFFE);
         chk("bp_state", {wb_valid, in_ready}, 2'b10);
         tick();
      end
      wb_ready = 1'b1;
      tick();
      chk("bp_release", {wb_valid, in_ready}, 2'b01);
      resp_delay = 0;

      // Reset while waiting on the M unit, then a stray completion
      resp_en = 1'b0;
      offer(32'h022081B3, 32'd9, 32'd9, 3'd5);
      repeat (3) tick();
      chk("stuck_wait", in_ready, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      stray_once = 1'b1;
      tick();
      repeat (2) tick();
      chk("abort_valids", {in_ready, cp_valid, wb_valid, wb_err}, 4'b1000);
      chk("abort_cp", {cp_func, cp_id}, 32'd0);
      chk("abort_ops", cp_op1 | cp_op2, 32'd0);
      chk("abort_wb", {wb_rd, wb_tag}, 32'd0);
      chk("abort_data", wb_data, 32'd0);
      resp_en = 1'b1;

      // Randomized traffic
      stray_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (reset) reset = 1'b0;
         else if ($urandom_range(0, 199) == 0) reset = 1'b1;
         in_valid   = $urandom_range(0, 1);
         in_instr   = gen_instr();
         in_rs1_val = gen_op();
         in_rs2_val = gen_op();
         in_tag     = 3'($urandom);
         wb_ready   = ($urandom_range(0, 2) != 0);
      end
      in_valid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
